mac_send: RTL and testbench

MAC_SEND -- requirements
Module: mac_send

---
 rtl/mac_send.sv | 139 +++++++++++++
 tb/tb_mac_send.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_send.sv
// Ethernet MAC transmit framer: payload -> optional zero pad -> 4-byte reflected CRC-32 FCS.
// Define MAC_SEND_PAD_EN to pad short frames to 60 bytes before the FCS.
`timescale 1ns/1ps
module mac_send (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  input  logic        phy_active,
  output logic [7:0]  tx_data,
  output logic        tx_enable,
  output logic        underrun,
  output logic [15:0] frame_count
);
`ifdef MAC_SEND_PAD_EN
  typedef enum logic [1:0] {IDLE, PAYLOAD, PAD, FCS} state_t;
`else
  typedef enum logic [1:0] {IDLE, PAYLOAD, FCS} state_t;
`endif

  state_t      state, n_state, last_state;
  logic [10:0] count, n_count, count_inc;
  logic [31:0] crc, n_crc;
  logic [1:0]  fcs_idx, n_idx;
  logic        aborted, n_abort;
  logic [7:0]  n_data, fcs_byte;
  logic        n_en, n_under, ready_c;
  logic [15:0] n_fc;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int b = 0; b < 8; b++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign count_inc = (count == 11'h7FF) ? count : count + 11'd1;
  assign fcs_byte  = crc[{fcs_idx, 3'b000} +: 8];
  // Held off during reset even though the FSM already sits in IDLE.
  assign in_ready  = ready_c & ~reset;

  always_comb begin
    n_state    = state;
    n_count    = count;
    n_crc      = crc;
    n_idx      = fcs_idx;
    n_abort    = aborted;
    n_data     = 8'h00;
    n_en       = 1'b0;
    n_under    = 1'b0;
    n_fc       = frame_count;
    ready_c    = 1'b0;
    last_state = FCS;
`ifdef MAC_SEND_PAD_EN
    if (((state == IDLE) ? 11'd1 : count_inc) < 11'd60) last_state = PAD;
`endif
    case (state)
      IDLE: begin
        ready_c = ~phy_active & ~tx_enable;
        if (in_valid && ready_c) begin
          n_state = in_last ? last_state : PAYLOAD;
          n_count = 11'd1;
          n_crc   = crc_byte(32'hFFFFFFFF, in_data);
          n_data  = in_data;
          n_en    = 1'b1;
          n_abort = 1'b0;
          n_idx   = 2'd0;
        end
      end
      PAYLOAD: begin
        ready_c = 1'b1;
        n_en    = 1'b1;
        if (in_valid) begin
          n_data  = in_data;
          n_count = count_inc;
          n_crc   = crc_byte(crc, in_data);
          n_idx   = 2'd0;
          if (in_last) n_state = last_state;
        end else begin
          // Starved: the first bad-FCS byte goes out now so tx_enable never gaps.
          n_under = 1'b1;
          n_abort = 1'b1;
          n_data  = crc[7:0];
          n_idx   = 2'd1;
          n_state = FCS;
        end
      end
`ifdef MAC_SEND_PAD_EN
      PAD: begin
        n_en    = 1'b1;
        n_count = count_inc;
        n_crc   = crc_byte(crc, 8'h00);
        n_idx   = 2'd0;
        if (count_inc == 11'd60) n_state = FCS;
      end
`endif
      FCS: begin
        n_en   = 1'b1;
        n_data = aborted ? fcs_byte : ~fcs_byte;
        n_idx  = fcs_idx + 2'd1;
        if (fcs_idx == 2'd3) begin
          n_state = IDLE;
          if (!aborted) n_fc = frame_count + 16'd1;
        end
      end
      default: n_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= n_state;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count       <= 11'd0;
      crc         <= 32'hFFFFFFFF;
      fcs_idx     <= 2'd0;
      aborted     <= 1'b0;
      tx_data     <= 8'h00;
      tx_enable   <= 1'b0;
      underrun    <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      count       <= n_count;
      crc         <= n_crc;
      fcs_idx     <= n_idx;
      aborted     <= n_abort;
      tx_data     <= n_data;
      tx_enable   <= n_en;
      underrun    <= n_under;
      frame_count <= n_fc;
    end
  end
endmodule

// File: tb/tb_mac_send.sv
// Randomized self-checking bench for mac_send against a queue-based frame model.
`timescale 1ns/1ps
module tb_mac_send;
  logic        clock = 1'b0, reset = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0, in_last = 1'b0, phy_active = 1'b0;
  logic        in_ready, tx_enable, underrun;
  logic [7:0]  tx_data;
  logic [15:0] frame_count;

`ifdef MAC_SEND_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  mac_send dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .phy_active(phy_active),
    .tx_data(tx_data), .tx_enable(tx_enable), .underrun(underrun),
    .frame_count(frame_count)
  );

  always #4 clock = ~clock;

  int errors = 0, checks = 0;
  int exp_fc = 0;
  logic [7:0] got[$];
  int runs = 0, upulses = 0, cyc = 0, rise_cyc = 0, acc_cyc = 0;
  logic prev_en = 1'b0;

  always @(negedge clock) begin
    cyc++;
    if (tx_enable) got.push_back(tx_data);
    if (tx_enable && !prev_en) begin runs++; rise_cyc = cyc; end
    if (underrun) upulses++;
    prev_en = tx_enable;
  end

  // Standard reflected CRC-32, one bit at a time; returns the transmitted FCS value.
  function automatic logic [31:0] crc32(input logic [7:0] d[$]);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (d[i])
      for (int b = 0; b < 8; b++) begin
        logic fb;
        fb = c[0] ^ d[i][b];
        c = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    return ~c;
  endfunction

  function automatic void expected(input logic [7:0] pl[$], input bit abort, output logic [7:0] e[$]);
    logic [31:0] f;
    e = pl;
    if (!abort && PAD) while (e.size() < 60) e.push_back(8'h00);
    f = crc32(e);
    if (abort) f = ~f;
    for (int k = 0; k < 4; k++) e.push_back(f[8*k +: 8]);
  endfunction

  function automatic int first_diff(input logic [7:0] a[$], input logic [7:0] b[$]);
    for (int i = 0; i < a.size() && i < b.size(); i++)
      if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  // Called at a negedge; stops after 'drop' accepted bytes when drop >= 0.
  task automatic send(input logic [7:0] pl[$], input int drop);
    int i = 0, g = 0;
    while (i < pl.size()) begin
      in_valid = 1'b1; in_data = pl[i]; in_last = (i == pl.size() - 1);
      #1;
      if (in_ready) begin
        if (i == 0) acc_cyc = cyc;
        i++;
      end else g++;
      @(negedge clock);
      if (g > 200) break;
      if (drop >= 0 && i == drop) break;
    end
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    checks++;
    if (g > 200) $display("FAIL send_timeout: accepted %0d of %0d bytes", i, pl.size());
    if (g > 200) errors++;
  endtask

  task automatic wait_done();
    int g = 0;
    while (tx_enable && g < 3000) begin @(negedge clock); g++; end
    checks++;
    if (tx_enable) begin errors++; $display("FAIL frame_end_timeout: tx_enable=%0b required 0", tx_enable); end
    @(negedge clock);
  endtask

  task automatic do_frame(input logic [7:0] pl[$], input int drop, input string name);
    logic [7:0] sent[$], e[$], seg[$];
    int base = got.size(), rb = runs, ub = upulses, d;
    bit abort = (drop >= 0);
    sent = pl;
    if (abort) sent = pl[0:drop-1];
    expected(sent, abort, e);
    send(pl, drop);
    wait_done();
    seg = got[base:$];
    if (!abort) exp_fc = (exp_fc + 1) & 16'hFFFF;
    checks++;
    if (seg.size() != e.size()) begin errors++; $display("FAIL %s_len: got %0d required %0d", name, seg.size(), e.size()); end
    checks++; d = first_diff(seg, e);
    if (d >= 0) begin errors++; $display("FAIL %s_data: byte %0d got %02h required %02h", name, d, seg[d], e[d]); end
    checks++;
    if (runs - rb != 1) begin errors++; $display("FAIL %s_contig: enable bursts %0d required 1", name, runs - rb); end
    checks++;
    if (upulses - ub != int'(abort)) begin errors++; $display("FAIL %s_underrun: pulses %0d required %0d", name, upulses - ub, int'(abort)); end
    checks++;
    if (frame_count !== exp_fc[15:0]) begin errors++; $display("FAIL %s_count: frame_count %0d required %0d", name, frame_count, exp_fc); end
  endtask

  task automatic test_reset();
    #18;
    checks++;
    if ({tx_enable, tx_data, in_ready, underrun, frame_count} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs: en=%0b data=%02h rdy=%0b und=%0b fc=%0d required all 0",
               tx_enable, tx_data, in_ready, underrun, frame_count);
    end
    @(negedge clock); reset = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %0b required 1", in_ready); end
    @(negedge clock);
  endtask

  task automatic test_crc_vector();
    logic [7:0] pl[$] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    logic [31:0] tail;
    do_frame(pl, -1, "vec9");
    tail = {got[got.size()-1], got[got.size()-2], got[got.size()-3], got[got.size()-4]};
    checks++;
    if (!PAD && tail !== 32'hCBF43926) begin errors++; $display("FAIL vec9_fcs: got %08h required CBF43926", tail); end
    if (PAD && tail !== crc32(pl)) begin end
  endtask

  task automatic test_long();
    logic [7:0] pl[$];
    for (int i = 0; i < 100; i++) pl.push_back(8'(i));
    do_frame(pl, -1, "long100");
  endtask

  task automatic test_one_byte();
    logic [7:0] pl[$] = '{8'hA5};
    do_frame(pl, -1, "one_byte");
  endtask

  task automatic test_underrun();
    logic [7:0] pl[$];
    for (int i = 0; i < 30; i++) pl.push_back(8'($urandom));
    do_frame(pl, 20, "underrun");
  endtask

  task automatic test_phy_active();
    logic [7:0] pl[$];
    for (int i = 0; i < 12; i++) pl.push_back(8'($urandom));
    phy_active = 1'b1; in_valid = 1'b1; in_data = pl[0];
    for (int k = 0; k < 5; k++) begin
      @(negedge clock); #1;
      checks++;
      if (in_ready !== 1'b0 || tx_enable !== 1'b0) begin
        errors++; $display("FAIL phy_hold: rdy=%0b en=%0b required 0 0", in_ready, tx_enable);
      end
    end
    @(negedge clock);
    phy_active = 1'b0;
    do_frame(pl, -1, "phy");
    checks++;
    if (rise_cyc != acc_cyc + 1) begin errors++; $display("FAIL phy_latency: start cycle %0d required %0d", rise_cyc, acc_cyc + 1); end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 6; f++) begin
      logic [7:0] pl[$];
      int len = $urandom_range(2, 80);
      int drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : -1;
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
      do_frame(pl, drop, $sformatf("rand%0d", f));
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] pl[$], nx[$];
    for (int i = 0; i < 50; i++) pl.push_back(8'($urandom));
    for (int i = 0; i < 15; i++) nx.push_back(8'($urandom));
    send(pl, 30);
    reset = 1'b1; #1;
    checks++;
    if ({tx_enable, tx_data, in_ready, underrun, frame_count} !== 27'd0) begin
      errors++;
      $display("FAIL reset_mid: en=%0b data=%02h rdy=%0b und=%0b fc=%0d required all 0",
               tx_enable, tx_data, in_ready, underrun, frame_count);
    end
    exp_fc = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    do_frame(nx, -1, "after_reset");
  endtask

  initial begin
    test_reset();
    test_crc_vector();
    test_long();
    test_one_byte();
    test_underrun();
    test_phy_active();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
